// File: rtl/glitc_dac_pkg.sv
// Shared constants and types for the GLITC DAC serial loader.
`timescale 1ns/1ps
package glitc_dac_pkg;

  // Register offsets within the 4-byte window (address[1:0])
  localparam logic [1:0] DAC_CMD_HI  = 2'd0;
  localparam logic [1:0] DAC_CMD_MID = 2'd1;
  localparam logic [1:0] DAC_CMD_LO  = 2'd2;
  localparam logic [1:0] DAC_CTRL    = 2'd3;

  // Control register bit positions
  localparam int GO_BIT    = 0;
  localparam int TRAIN_BIT = 1;
  localparam int OVR_BIT   = 2;

  // Length of one DAC command word
  localparam int DAC_BITS = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2,
    LATCH = 2'd3
  } dac_state_t;

endpackage

// File: rtl/glitc_dac_sclk_div.sv
// Phase timer for the DAC serial clock: a loadable down-counter that
// flags the last cycle of each CLKDIV-long phase.
`timescale 1ns/1ps
module glitc_dac_sclk_div #(
  parameter int CLKDIV = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic load,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(CLKDIV - 1);

  logic [7:0] count;

  // Reload at every phase boundary, otherwise count down and park at zero
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count <= RELOAD;
    end else if (load) begin
      count <= RELOAD;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign tick = (count == 8'd0);

endmodule

// File: rtl/glitc_dac_loader.sv
// GLITCBUS register window that shifts a 24-bit command into the DAC
// chain (MSB first), pulses LATCH, captures DOUT as readback and owns
// the TRAINING_ON level.
`timescale 1ns/1ps
module glitc_dac_loader #(
  parameter logic [13:0] BASE   = 14'h0040,
  parameter int          CLKDIV = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        sel_i,
  input  logic        wr_i,
  input  logic        rd_i,
  input  logic [13:0] address_i,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  output logic        ack_o,
  output logic        dac_din_o,
  output logic        dac_clk_o,
  output logic        dac_latch_o,
  input  logic        dac_dout_i,
  output logic        training_o
);

  import glitc_dac_pkg::*;

  dac_state_t            state;
  logic [DAC_BITS-1:0]   cmd;
  logic [DAC_BITS-1:0]   sh;
  logic [DAC_BITS-1:0]   rb;
  logic [4:0]            bit_cnt;
  logic                  overrun;
  logic                  tick;
  logic                  div_load;

  logic hit, is_wr, is_rd, ctrl_wr, busy, go_req, go_ok, go_rej;

  // Access decode; a combined read+write strobe is treated as a write
  always_comb begin
    hit     = sel_i & (wr_i | rd_i) & (address_i[13:2] == BASE[13:2]);
    is_wr   = hit & wr_i;
    is_rd   = hit & ~wr_i;
    ctrl_wr = is_wr & (address_i[1:0] == DAC_CTRL);
    busy    = (state != IDLE);
    go_req  = ctrl_wr & data_i[GO_BIT];
    go_ok   = go_req & ~busy;
    go_rej  = go_req & busy;
  end

  // Command byte registers; the shifter takes its own copy on go, so
  // these may be rewritten while a word is going out
  for (genvar gi = 0; gi < 3; gi++) begin : g_cmd_byte
    logic [7:0] cmd_byte;

    // Capture a write to this byte's offset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        cmd_byte <= 8'h00;
      end else if (is_wr && (address_i[1:0] == 2'(gi))) begin
        cmd_byte <= data_i;
      end
    end

    assign cmd[DAC_BITS-1-8*gi -: 8] = cmd_byte;
  end

  // Bus response, control register and sticky overrun flag
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack_o      <= 1'b0;
      data_o     <= 8'h00;
      training_o <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      ack_o <= hit;
      if (is_rd) begin
        case (address_i[1:0])
          DAC_CMD_HI:  data_o <= rb[23:16];
          DAC_CMD_MID: data_o <= rb[15:8];
          DAC_CMD_LO:  data_o <= rb[7:0];
          default:     data_o <= {5'b0, overrun, training_o, busy};
        endcase
      end
      if (ctrl_wr) begin
        training_o <= data_i[TRAIN_BIT];
      end
      // Clear applies to the old flag; a rejected go in the same write
      // still leaves the flag set
      overrun <= (overrun & ~(ctrl_wr & data_i[OVR_BIT])) | go_rej;
    end
  end

  // Phase timer restarts on every state change and is held while idle
  assign div_load = (state == IDLE) | tick;

  glitc_dac_sclk_div #(
    .CLKDIV (CLKDIV)
  ) u_div (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load    (div_load),
    .tick    (tick)
  );

  // Serial shift sequencer with registered DAC pins
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      sh          <= '0;
      rb          <= '0;
      bit_cnt     <= 5'd0;
      dac_din_o   <= 1'b0;
      dac_clk_o   <= 1'b0;
      dac_latch_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go_ok) begin
            sh        <= cmd;
            bit_cnt   <= 5'd0;
            dac_din_o <= cmd[DAC_BITS-1];
            dac_clk_o <= 1'b0;
            state     <= LOW;
          end
        end
        LOW: begin
          if (tick) begin
            // Rising SCLK: the DAC takes DIN, we take DOUT
            dac_clk_o <= 1'b1;
            sh        <= {sh[DAC_BITS-2:0], dac_dout_i};
            bit_cnt   <= (bit_cnt == 5'(DAC_BITS)) ? bit_cnt : bit_cnt + 5'd1;
            state     <= HIGH;
          end
        end
        HIGH: begin
          if (tick) begin
            dac_clk_o <= 1'b0;
            if (bit_cnt == 5'(DAC_BITS)) begin
              dac_din_o   <= 1'b0;
              dac_latch_o <= 1'b1;
              state       <= LATCH;
            end else begin
              dac_din_o <= sh[DAC_BITS-1];
              state     <= LOW;
            end
          end
        end
        default: begin
          if (tick) begin
            rb          <= sh;
            dac_latch_o <= 1'b0;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glitc_dac_loader.sv
// Self-checking bench for glitc_dac_loader (CLKDIV=2).
`timescale 1ns/1ps
module tb_glitc_dac_loader;

  localparam int          CLKDIV = 2;
  localparam logic [13:0] BASE   = 14'h0040;
  localparam int          BUSY_CYCLES = 49 * CLKDIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [13:0] address = '0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic        ack, dac_din, dac_clk, dac_latch, dac_dout, training;

  glitc_dac_loader #(.BASE(BASE), .CLKDIV(CLKDIV)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .sel_i       (sel),
    .wr_i        (wr),
    .rd_i        (rd),
    .address_i   (address),
    .data_i      (data_in),
    .data_o      (data_out),
    .ack_o       (ack),
    .dac_din_o   (dac_din),
    .dac_clk_o   (dac_clk),
    .dac_latch_o (dac_latch),
    .dac_dout_i  (dac_dout),
    .training_o  (training)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // DAC-side observer: counts SCLK rises, collects DIN at each rise,
  // counts LATCH cycles and checks DIN stability around the rise
  int          edge_cnt = 0, latch_cycles = 0, stable_errs = 0, low_run = 0;
  logic [23:0] din_word = '0;
  logic        prev_clk = 1'b0, prev_din = 1'b0;

  always @(negedge clk) begin
    if (dac_clk && !prev_clk) begin
      edge_cnt <= edge_cnt + 1;
      din_word <= {din_word[22:0], dac_din};
      if (low_run < CLKDIV) stable_errs <= stable_errs + 1;
    end else if (dac_clk && prev_clk && dac_din !== prev_din) begin
      stable_errs <= stable_errs + 1;
    end
    low_run      <= !dac_clk ? ((!prev_clk && dac_din === prev_din) ? low_run + 1 : 1) : 0;
    latch_cycles <= latch_cycles + (dac_latch ? 1 : 0);
    prev_clk     <= dac_clk;
    prev_din     <= dac_din;
  end

  // DAC readback source: loop DIN back, or play a chosen 24-bit pattern
  logic        loop_mode = 1'b1;
  logic [23:0] dout_pat = '0;
  int          edge_base = 0;
  int          rel;
  logic        pat_bit;

  always_comb begin
    rel     = edge_cnt - edge_base;
    pat_bit = 1'b0;
    if (rel >= 0 && rel < 24) pat_bit = dout_pat[23 - rel];
  end

  assign dac_dout = loop_mode ? dac_din : pat_bit;

  // Behavioural model of the register view
  logic [23:0] mdl_cmd = '0, mdl_rb = '0, mdl_word = '0;
  logic        mdl_ovr = 1'b0, mdl_training = 1'b0, mdl_busy = 1'b0;
  logic [7:0]  last_q = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mdl_cmd = '0; mdl_rb = '0; mdl_ovr = 1'b0; mdl_training = 1'b0; mdl_busy = 1'b0;
  endtask

  // One bus access; returns on the negedge of the cycle where ack is due
  task automatic bus(input logic s, input logic w, input logic r, input logic [13:0] a,
                     input logic [7:0] d, input logic exp_ack, input string tag,
                     output logic [7:0] q);
    @(negedge clk);
    sel = s; wr = w; rd = r; address = a; data_in = d;
    @(negedge clk);
    sel = 1'b0; wr = 1'b0; rd = 1'b0;
    check({tag, " ack"}, {31'b0, ack}, {31'b0, exp_ack});
    q = data_out;
  endtask

  task automatic wr_reg(input logic [1:0] off, input logic [7:0] d, input string tag);
    logic [7:0] q;
    bus(1'b1, 1'b1, 1'b0, {BASE[13:2], off}, d, 1'b1, tag, q);
    case (off)
      2'd0: mdl_cmd[23:16] = d;
      2'd1: mdl_cmd[15:8]  = d;
      2'd2: mdl_cmd[7:0]   = d;
      default: begin
        if (d[2]) mdl_ovr = 1'b0;
        mdl_training = d[1];
        if (d[0]) begin
          if (mdl_busy) mdl_ovr = 1'b1;
          else begin
            mdl_busy = 1'b1;
            mdl_word = mdl_cmd;
          end
        end
      end
    endcase
  endtask

  task automatic rd_reg(input logic [1:0] off, input string tag);
    logic [7:0] q, e;
    bus(1'b1, 1'b0, 1'b1, {BASE[13:2], off}, 8'h00, 1'b1, tag, q);
    case (off)
      2'd0:    e = mdl_rb[23:16];
      2'd1:    e = mdl_rb[15:8];
      2'd2:    e = mdl_rb[7:0];
      default: e = {5'b0, mdl_ovr, mdl_training, mdl_busy};
    endcase
    check(tag, {24'b0, q}, {24'b0, e});
    last_q = q;
  endtask

  // Called on the ack cycle of an accepted go; counts busy cycles until
  // the latch pulse ends, then lets the observer settle
  task automatic wait_done(output int n);
    logic seen, done;
    seen = 1'b0; done = 1'b0; n = 1;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (!dac_latch && seen) done = 1'b1;
      else begin
        if (dac_latch) seen = 1'b1;
        n++;
      end
    end
    check("shift completes in budget", {31'b0, done}, 32'd1);
    mdl_busy = 1'b0;
    mdl_rb   = loop_mode ? mdl_word : dout_pat;
    repeat (2) @(negedge clk);
  endtask

  // Full transaction: optional cmd load, go, and checks of the DAC waveform
  task automatic do_shift(input logic load_cmd, input logic [23:0] c, input logic lp,
                          input logic [23:0] pat, input string tag);
    int n, e0, l0, s0;
    if (load_cmd) begin
      wr_reg(2'd0, c[23:16], {tag, " wr hi"});
      wr_reg(2'd1, c[15:8],  {tag, " wr mid"});
      wr_reg(2'd2, c[7:0],   {tag, " wr lo"});
    end
    loop_mode = lp; dout_pat = pat;
    e0 = edge_cnt; l0 = latch_cycles; s0 = stable_errs; edge_base = e0;
    wr_reg(2'd3, 8'h01, {tag, " go"});
    wait_done(n);
    check({tag, " busy cycles"}, n, BUSY_CYCLES);
    check({tag, " sclk rises"}, edge_cnt - e0, 24);
    check({tag, " din word"}, {8'b0, din_word}, {8'b0, c});
    check({tag, " latch cycles"}, latch_cycles - l0, CLKDIV);
    check({tag, " din stability"}, stable_errs - s0, 0);
    rd_reg(2'd0, {tag, " rb hi"});
    rd_reg(2'd1, {tag, " rb mid"});
    rd_reg(2'd2, {tag, " rb lo"});
    rd_reg(2'd3, {tag, " status idle"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  q;
    logic [23:0] c, p;
    int          n, e0, l0;
    logic        reached;

    // Reset values
    model_reset();
    repeat (3) @(negedge clk);
    check("reset dac_clk", {31'b0, dac_clk}, 0);
    check("reset dac_din", {31'b0, dac_din}, 0);
    check("reset dac_latch", {31'b0, dac_latch}, 0);
    check("reset training", {31'b0, training}, 0);
    check("reset ack", {31'b0, ack}, 0);
    check("reset data_o", {24'b0, data_out}, 0);
    rst_n = 1'b1;
    rd_reg(2'd3, "reset status");
    @(negedge clk);
    check("ack single cycle", {31'b0, ack}, 0);

    // Directed full shift with loopback
    do_shift(1'b1, 24'hA5C33C, 1'b1, 24'h0, "loop a5c33c");

    // Randomized words with an independent DOUT pattern
    for (int k = 0; k < 3; k++) begin
      c = 24'($urandom());
      p = 24'($urandom());
      do_shift(1'b1, c, 1'b0, p, $sformatf("rand%0d", k));
    end

    // Overrun: go while busy, then clear while still busy
    c = 24'($urandom());
    wr_reg(2'd0, c[23:16], "ovr wr hi");
    wr_reg(2'd1, c[15:8],  "ovr wr mid");
    wr_reg(2'd2, c[7:0],   "ovr wr lo");
    loop_mode = 1'b1;
    e0 = edge_cnt; l0 = latch_cycles; edge_base = e0;
    wr_reg(2'd3, 8'h01, "ovr go");
    repeat (8) @(negedge clk);
    wr_reg(2'd3, 8'h01, "ovr go while busy");
    rd_reg(2'd3, "ovr status set");
    wr_reg(2'd3, 8'h04, "ovr clear");
    rd_reg(2'd3, "ovr status cleared busy");
    wait_done(n);
    check("ovr sclk rises", edge_cnt - e0, 24);
    check("ovr din word", {8'b0, din_word}, {8'b0, c});
    check("ovr latch cycles", latch_cycles - l0, CLKDIV);
    rd_reg(2'd3, "ovr status done");

    // cmd rewrite during a shift does not disturb the word in flight
    wr_reg(2'd0, 8'h00, "mid wr hi");
    wr_reg(2'd1, 8'h00, "mid wr mid");
    wr_reg(2'd2, 8'h00, "mid wr lo");
    e0 = edge_cnt;
    wr_reg(2'd3, 8'h01, "mid go");
    repeat (10) @(negedge clk);
    wr_reg(2'd0, 8'hFF, "mid wr hi busy");
    wait_done(n);
    check("mid first word", {8'b0, din_word}, 32'h0);
    check("mid first rises", edge_cnt - e0, 24);
    do_shift(1'b0, 24'hFF0000, 1'b1, 24'h0, "mid second");

    // Decode: wrong base and deselected accesses are ignored
    bus(1'b1, 1'b1, 1'b0, 14'h0083, 8'h03, 1'b0, "wrong base", q);
    repeat (4) @(negedge clk);
    check("wrong base no shift", {31'b0, dac_clk}, 0);
    check("wrong base training", {31'b0, training}, 0);
    bus(1'b0, 1'b1, 1'b0, {BASE[13:2], 2'd3}, 8'h03, 1'b0, "sel low", q);
    repeat (4) @(negedge clk);
    check("sel low no shift", {31'b0, dac_clk}, 0);
    rd_reg(2'd3, "decode status");
    bus(1'b1, 1'b1, 1'b1, {BASE[13:2], 2'd3}, 8'h02, 1'b1, "wr+rd", q);
    mdl_training = 1'b1;
    check("wr+rd training", {31'b0, training}, 1);
    check("wr+rd data_o held", {24'b0, data_out}, {24'b0, last_q});
    rd_reg(2'd3, "training status");
    wr_reg(2'd3, 8'h00, "training off");

    // Asynchronous reset in the middle of a word
    c = 24'($urandom());
    wr_reg(2'd0, c[23:16], "rst wr hi");
    wr_reg(2'd1, c[15:8],  "rst wr mid");
    wr_reg(2'd2, c[7:0],   "rst wr lo");
    rd_reg(2'd0, "rst pre-read rb");
    e0 = edge_cnt; l0 = latch_cycles;
    wr_reg(2'd3, 8'h03, "rst go");
    reached = 1'b0;
    for (int i = 0; i < 400 && !reached; i++) begin
      @(negedge clk);
      if (edge_cnt - e0 >= 12) reached = 1'b1;
    end
    check("rst reached bit 12", {31'b0, reached}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst dac_clk", {31'b0, dac_clk}, 0);
    check("rst dac_din", {31'b0, dac_din}, 0);
    check("rst dac_latch", {31'b0, dac_latch}, 0);
    check("rst training", {31'b0, training}, 0);
    check("rst ack", {31'b0, ack}, 0);
    check("rst data_o", {24'b0, data_out}, 0);
    model_reset();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst no latch", latch_cycles - l0, 0);
    rd_reg(2'd0, "rst rb hi");
    rd_reg(2'd1, "rst rb mid");
    rd_reg(2'd2, "rst rb lo");
    rd_reg(2'd3, "rst status");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/glitc_dac_loader.md
# glitc_dac_loader

Serial configuration controller for one GLITC half's threshold/bias DAC chain. It exposes a 4-byte register window on the internal GLITCBUS register interface, behind the glitcbus slave, alongside a `top_glitc` instance. It also shifts a 24-bit command word MSB-first into the DAC, pulses LATCH, and captures DAC DOUT as readback. It owns the half's TRAINING_ON output. One instance per half: A and B.

## Interface
Parameters:
- `BASE`, default 14'h0040: register window base; `address_i[13:2]` must equal `BASE[13:2]`.
- `CLKDIV`, default 4: clk_i cycles per SCLK half-period; legal range 1..255.

Ports:
- `clk_i` input 1: system clock, the only clock.
- `rst_n_i` input 1: reset, asynchronous, active-low.
- `sel_i` input 1: this half selected by the bus slave.
- `wr_i` input 1: single-cycle write strobe.
- `rd_i` input 1: single-cycle read strobe.
- `address_i` input 14: register address.
- `data_i` input 8: write data.
- `data_o` output 8: read data, valid when `ack_o` is high.
- `ack_o` output 1: single-cycle access acknowledge.
- `dac_din_o` output 1: serial data to DAC.
- `dac_clk_o` output 1: DAC SCLK; DAC samples on rising edge.
- `dac_latch_o` output 1: active-high load pulse.
- `dac_dout_i` input 1: DAC serial readback.
- `training_o` output 1: drives TRAINING_ON.

## Operation
Register map, selected by `address_i[1:0]`:
- 0: write sets `cmd[23:16]`; read returns `rb[23:16]`.
- 1: write sets `cmd[15:8]`; read returns `rb[15:8]`.
- 2: write sets `cmd[7:0]`; read returns `rb[7:0]`.
- 3, write: bit0 `go` (self-clearing), bit1 `training` level, bit2 write-1-to-clear `overrun`.
- 3, read: {5'b0, overrun, training, busy}.

Access rules:
- An access is decoded when `sel_i & (wr_i|rd_i)` and the base matches. A non-matching access gets no ack.
- If `wr_i` and `rd_i` are high together, the access is a write.
- `cmd` registers accept writes at any time. An in-flight shift is unaffected, because `cmd` is copied to the shift register on `go`.
- `go` while busy is ignored and sets sticky `overrun`. If `go` and overrun-clear arrive in the same write, the clear wins for the old flag, but a busy-reject still sets `overrun`.

FSM states:
- IDLE: on accepted `go`, load `sh <= cmd` and go to LOW.
- LOW: `dac_clk_o`=0 and `dac_din_o`=`sh[23]`. After CLKDIV cycles, go to HIGH.
- HIGH: `dac_clk_o`=1. On entry, shift in `sh <= {sh[22:0], dac_dout_i}` and increment the bit count. After CLKDIV cycles, go to LOW; after the 24th bit, go to LATCH.
- LATCH: `dac_clk_o`=0 and `dac_latch_o`=1 for CLKDIV cycles, then `rb <= sh`, then return to IDLE.

Other rules:
- `busy` = state != IDLE.
- Bit counter is 5 bits and saturates at 24. Divider counter is 8 bits, reloaded on every state change.
- Async reset mid-shift aborts immediately. The DAC sees an incomplete word with no latch, which is harmless because no LATCH is issued.

## Timing
- Reset values: `data_o`=0, `ack_o`=0, `dac_din_o`=0, `dac_clk_o`=0, `dac_latch_o`=0, `training_o`=0. Also `cmd`=0, `rb`=0, `overrun`=0, state IDLE.
- Ack timing: `ack_o` goes high exactly 1 cycle after the strobe, for 1 cycle. `data_o` is registered in the same cycle and held until the next read.
- Write effects are visible on the ack cycle. `training_o` updates on the ack cycle.
- Shift start: an accepted `go` enters LOW on the ack cycle.
- Shift length: busy lasts 48·CLKDIV + CLKDIV cycles. `busy` reads 0 on the first cycle after LATCH ends.
- Data/clock relationship: `dac_din_o` is stable CLKDIV cycles before each SCLK rising edge and holds through the high phase.
- Readback: `rb` holds the 24 bits sampled on the rising edges, in MSB-first order.

## Structure
- Package `glitc_dac_pkg`: register offsets (`DAC_CMD_HI/MID/LO`, `DAC_CTRL`), ctrl bit positions (`GO_BIT`, `TRAIN_BIT`, `OVR_BIT`), state enum `{IDLE, LOW, HIGH, LATCH}`, `DAC_BITS`=24.
- Sub-module `glitc_dac_sclk_div`: loadable down-counter producing a `tick` at phase end; the FSM consumes `tick`.
- Bus decode and FSM stay in this module.

## Test plan
- Reset values: assert `rst_n_i`=0, release, read offset 3 → ack 1 cycle later, `data_o`=8'h00. All DAC outputs are 0.
- Full shift, CLKDIV=2, `dac_dout_i` looped to `dac_din_o`: write 0xA5, 0xC3, 0x3C to offsets 0–2, then write 8'h01 to offset 3. Required response:
  - exactly 24 SCLK rising edges, with DIN sampled = 0xA5C33C;
  - `dac_latch_o` high for 2 cycles;
  - busy for 98 cycles;
  - reads of offsets 0–2 return A5/C3/3C.
- Overrun: write `go` at cycle 10 of a shift → status = 8'h05 and exactly 24 edges. Then write 8'h04 → status reads 8'h01 while busy, 8'h00 after done.
- `cmd` write mid-shift: write 0xFF to offset 0 during a shift of 0x000000 → DIN stays all zeros. A following `go` shifts 0xFF0000.
- Decode: access with wrong base or with `sel_i`=0 → no `ack_o`, no state change. Simultaneous `wr_i`/`rd_i` to offset 3 with data 8'h02 → `training_o`=1 on the ack cycle.
- Reset mid-shift: drop `rst_n_i` at bit 12 → all outputs 0 asynchronously, no latch pulse, `rb` stays 0.
